// File: rtl/driver_leds_ctrl.sv
// Memory-mapped LED controller: direct write, atomic set/clear/toggle, per-LED blink, status readback.
// Optional PWM dimming on register 7 when DRIVER_LEDS_PWM_EN is defined.
module driver_leds_ctrl #(
  parameter int N_LEDS      = 10,
  parameter int DATA_W      = 32,
  parameter int BLINK_DIV_W = 24,
  parameter int PWM_W       = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                chip_select,
  input  logic                write_enable,
  input  logic [2:0]          addr,
  input  logic [DATA_W-1:0]   data_write,
  output logic [DATA_W-1:0]   data_read,
  output logic [N_LEDS-1:0]   ledr
);

  localparam logic [BLINK_DIV_W-1:0] BCNT_ONE = 1;

  logic [N_LEDS-1:0]      r_led;
  logic [N_LEDS-1:0]      r_bmask;
  logic [N_LEDS-1:0]      r_ledr;
  logic [BLINK_DIV_W-1:0] r_bper;
  logic [BLINK_DIV_W-1:0] r_bcnt;
  logic                   r_phase;
  logic [DATA_W-1:0]      r_data_read;

  logic                   w_wr;
  logic [N_LEDS-1:0]      w_wdata;
  logic                   w_pwm_gate;
  logic [DATA_W-1:0]      w_rd_val;

  assign w_wr    = chip_select & write_enable;
  assign w_wdata = data_write[N_LEDS-1:0];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_led <= '0;
    end else if (w_wr) begin
      case (addr)
        3'd0:    r_led <= w_wdata;
        3'd1:    r_led <= r_led | w_wdata;
        3'd2:    r_led <= r_led & ~w_wdata;
        3'd3:    r_led <= r_led ^ w_wdata;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_bmask <= '0;
    end else if (w_wr && addr == 3'd4) begin
      r_bmask <= w_wdata;
    end
  end

  // A period write restarts the blink cycle and takes priority over a toggle in the same cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_bper  <= '0;
      r_bcnt  <= '0;
      r_phase <= 1'b1;
    end else if (w_wr && addr == 3'd5) begin
      r_bper  <= data_write[BLINK_DIV_W-1:0];
      r_bcnt  <= '0;
      r_phase <= 1'b1;
    end else if (r_bper == '0) begin
      r_bcnt  <= '0;
      r_phase <= 1'b1;
    end else if (r_bcnt == r_bper - BCNT_ONE) begin
      r_bcnt  <= '0;
      r_phase <= ~r_phase;
    end else begin
      r_bcnt  <= r_bcnt + BCNT_ONE;
    end
  end

`ifdef DRIVER_LEDS_PWM_EN
  localparam logic [PWM_W-1:0] DUTY_MAX = '1;
  localparam logic [PWM_W-1:0] PWM_ONE  = 1;

  logic [PWM_W-1:0] r_duty;
  logic [PWM_W-1:0] r_pwm_cnt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_duty    <= DUTY_MAX;
      r_pwm_cnt <= '0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + PWM_ONE;
      if (w_wr && addr == 3'd7) begin
        r_duty <= data_write[PWM_W-1:0];
      end
    end
  end

  // Full-scale duty is steady on rather than off for one count in every period.
  assign w_pwm_gate = (r_pwm_cnt < r_duty) | (r_duty == DUTY_MAX);
`else
  assign w_pwm_gate = 1'b1;
`endif

  always_comb begin
    w_rd_val = '0;
    case (addr)
      3'd0, 3'd1, 3'd2, 3'd3: w_rd_val[N_LEDS-1:0]      = r_led;
      3'd4:                   w_rd_val[N_LEDS-1:0]      = r_bmask;
      3'd5:                   w_rd_val[BLINK_DIV_W-1:0] = r_bper;
      3'd6:                   w_rd_val[0]               = r_phase;
`ifdef DRIVER_LEDS_PWM_EN
      3'd7:                   w_rd_val[PWM_W-1:0]       = r_duty;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_ledr      <= '0;
      r_data_read <= '0;
    end else begin
      r_ledr <= r_led & ~(r_bmask & {N_LEDS{~r_phase}}) & {N_LEDS{w_pwm_gate}};
      if (chip_select) begin
        r_data_read <= w_rd_val;
      end
    end
  end

  assign ledr      = r_ledr;
  assign data_read = r_data_read;

endmodule
